lzw_dict_ram: RTL and testbench
===============================

// Module: lzw_dict_ram
// PURPOSE
//  Parametrised, banked, dual-port code-value store for the LZW dictionary.
//  Port A is the compressor lookup path (read/write); port B is the dictionary-update path (write-only).
//  Adds port-B->A write forwarding, a read-valid strobe and a flush engine that sweeps every entry to INIT_VAL.
//  Sits between the LZW control FSM and the hash/lookup logic.
// PARAMETERS
//  DATA_W          13     code-value width in bits
//  ADDR_W          13     word address width; DEPTH = 2**ADDR_W
//  BANK_BITS       2      log2(number of banks); NUM_BANKS = 2**BANK_BITS
//  INIT_VAL        0      value written to every entry by a flush
//  CLEAR_ON_RESET  1      1: start a flush automatically when rst deasserts
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        pulse: clear whole dictionary to INIT_VAL
//  busy       out  1        high while flush sweep in progress
//  a_en       in   1        port A access enable
//  a_we       in   1        port A write (with a_en)
//  a_addr     in   ADDR_W   port A word address
//  a_wdata    in   DATA_W   port A write data
//  a_rdata    out  DATA_W   port A read data, held between reads
//  a_rvalid   out  1        one-cycle strobe: a_rdata updated this cycle
//  b_en       in   1        port B enable
//  b_we       in   1        port B write (with b_en)
//  b_addr     in   ADDR_W   port B word address
//  b_wdata    in   DATA_W   port B write data
// BEHAVIOUR
//  - Addressing: bank = addr[BANK_BITS-1:0], row = addr[ADDR_W-1:BANK_BITS]; only the selected bank is enabled.
//  - Reset values: a_rdata=0, a_rvalid=0, busy=CLEAR_ON_RESET, row counter=0. RAM contents are not reset.
//  - Port A read (a_en & !a_we & !busy) at cycle N: a_rdata valid and a_rvalid=1 at N+1.
//    With no read in progress, a_rdata holds its last value and a_rvalid=0.
//  - Port A write (a_en & a_we): written at posedge; a_rvalid stays 0; a_rdata unchanged.
//  - Port B write (b_en & b_we): written at posedge. b_en & !b_we is a no-op.
//  - Forwarding: A-read and B-write to the same address in the same cycle -> a_rdata(N+1) = b_wdata.
//  - Write collision: A-write and B-write to the same address in the same cycle -> port B data stored.
//  - Different addresses (same bank, different rows): both operations complete independently.
//  - Flush FSM, states IDLE, CLEAR:
//      IDLE -> CLEAR on flush, or on first clk after rst release when CLEAR_ON_RESET=1.
//      CLEAR: writes INIT_VAL to row cnt of all banks in parallel, cnt++.
//      CLEAR -> IDLE after row DEPTH/NUM_BANKS-1 is written.
//      Sweep lasts DEPTH/NUM_BANKS cycles; busy is high for exactly those cycles.
//  - While busy: a_en and b_en are ignored (no writes; a_rvalid=0; a_rdata holds).
//  - flush asserted while in CLEAR: cnt restarts at 0, sweep is extended.
//  - A read issued in the same cycle as flush is ignored (busy becomes 1 that edge).
//  - rst mid-sweep: FSM returns to reset state (IDLE, or re-enters CLEAR when CLEAR_ON_RESET=1).
//  - Unknown/out-of-range addresses cannot occur (full ADDR_W decode).
// STRUCTURE
//  - Package lzw_pkg: LZW_CODE_W=13, LZW_ADDR_W=13, LZW_BANK_BITS=2, and the flush state enum {ST_IDLE, ST_CLEAR}.
//  - Sub-module lzw_ram_bank: one bank of DEPTH/NUM_BANKS x DATA_W.
//      Port A: sync read/write. Port B: write-only.
//      Instantiated NUM_BANKS times in a generate loop.
//  - Top level holds:
//      bank decode
//      flush FSM and row counter
//      forwarding compare register
//      registered bank-select for the output mux
//      a_rdata hold register
// TESTING (defaults unless noted)
//  1. Reset release with CLEAR_ON_RESET=1 -> busy=1 for 2048 cycles, then 0; read of any address -> 0.
//  2. B writes 0x1ABC @0x0005; A reads 0x0005 next cycle -> a_rdata=0x1ABC, a_rvalid=1 one cycle later;
//     a_rdata holds 0x1ABC while a_en=0.
//  3. Same-cycle B-write 0x0123 @0x0010 and A-read @0x0010 -> a_rdata=0x0123 next cycle.
//  4. Same-cycle A-write 0x0AAA and B-write 0x0555 @0x0020 -> later read returns 0x0555.
//  5. Write all four banks (addr 0x40..0x43 = 1,2,3,4); read back in order -> 1,2,3,4 on consecutive cycles.
//  6. flush pulse, then flush again at sweep row 100 -> busy lasts 100+2048 cycles;
//     writes during busy are dropped; rst asserted mid-sweep -> busy restarts from row 0.

Source files
------------

// File: rtl/lzw_pkg.sv
// Shared widths and flush-engine state type for the LZW dictionary store.
package lzw_pkg;

    localparam int unsigned LZW_CODE_W    = 13;
    localparam int unsigned LZW_ADDR_W    = 13;
    localparam int unsigned LZW_BANK_BITS = 2;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } flush_state_e;

endpackage

// File: rtl/lzw_ram_bank.sv
// One dictionary bank: port A synchronous read/write, port B write-only.
module lzw_ram_bank #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned ROW_W  = 11
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ROW_W-1:0]  a_row,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic [ROW_W-1:0]  b_row,
    input  logic [DATA_W-1:0] b_wdata
);

    logic [DATA_W-1:0] mem [2**ROW_W];

    // Port B write is ordered last so it wins a same-row collision with port A.
    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_row] <= a_wdata;
            end else begin
                a_rdata <= mem[a_row];
            end
        end
        if (b_we) begin
            mem[b_row] <= b_wdata;
        end
    end

endmodule

// File: rtl/lzw_dict_ram.sv
// Banked dual-port LZW dictionary with B->A write forwarding, read strobe and flush sweep.
module lzw_dict_ram
    import lzw_pkg::*;
#(
    parameter int unsigned       DATA_W         = LZW_CODE_W,
    parameter int unsigned       ADDR_W         = LZW_ADDR_W,
    parameter int unsigned       BANK_BITS      = LZW_BANK_BITS,
    parameter logic [DATA_W-1:0] INIT_VAL       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              busy,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata
);

    localparam int unsigned NUM_BANKS = 2**BANK_BITS;
    localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
    localparam flush_state_e RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    flush_state_e         state_q, state_d;
    logic [ROW_W-1:0]     cnt_q, cnt_d;

    logic [BANK_BITS-1:0] a_bank, b_bank, bank_q;
    logic [ROW_W-1:0]     a_row, b_row, b_row_mux;
    logic [DATA_W-1:0]    b_wdata_mux;
    logic                 a_rd, a_wr, b_wr;
    logic                 rd_q, fwd_q;
    logic [DATA_W-1:0]    fwd_data_q, hold_q;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    assign a_bank = a_addr[BANK_BITS-1:0];
    assign a_row  = a_addr[ADDR_W-1:BANK_BITS];
    assign b_bank = b_addr[BANK_BITS-1:0];
    assign b_row  = b_addr[ADDR_W-1:BANK_BITS];

    assign busy = (state_q == ST_CLEAR);

    // A read coinciding with a flush request is dropped: the sweep owns the RAM next cycle.
    assign a_rd = a_en & ~a_we & ~busy & ~flush;
    assign a_wr = a_en & a_we & ~busy;
    assign b_wr = b_en & b_we & ~busy;

    assign b_row_mux   = busy ? cnt_q : b_row;
    assign b_wdata_mux = busy ? INIT_VAL : b_wdata;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic a_sel, b_sel;
        assign a_sel = (a_bank == BANK_BITS'(i));
        assign b_sel = (b_bank == BANK_BITS'(i));

        lzw_ram_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk     (clk),
            .a_en    ((a_rd | a_wr) & a_sel),
            .a_we    (a_we),
            .a_row   (a_row),
            .a_wdata (a_wdata),
            .a_rdata (bank_rdata[i]),
            .b_we    (busy | (b_wr & b_sel)),
            .b_row   (b_row_mux),
            .b_wdata (b_wdata_mux)
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (&cnt_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            bank_q     <= '0;
            hold_q     <= '0;
        end else begin
            rd_q  <= a_rd;
            fwd_q <= a_rd & b_wr & (a_addr == b_addr);
            if (a_rd) begin
                bank_q     <= a_bank;
                fwd_data_q <= b_wdata;
            end
            if (rd_q) begin
                hold_q <= a_rdata;
            end
        end
    end

    // Fresh data is shown in the strobe cycle, then latched so it holds afterwards.
    always_comb begin
        a_rdata = hold_q;
        if (rd_q) begin
            a_rdata = fwd_q ? fwd_data_q : bank_rdata[bank_q];
        end
    end

    assign a_rvalid = rd_q;

endmodule

// File: tb/tb_lzw_dict_ram.sv
// Self-checking bench for lzw_dict_ram: read scoreboard keyed by due cycle plus flush timing.
module tb_lzw_dict_ram;

    localparam int unsigned DW   = 13;
    localparam int unsigned AW   = 13;
    localparam int unsigned ROWS = 2048;

    typedef struct {
        int          cyc;
        logic [12:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          busy;
    logic          a_en, a_we, b_en, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata;
    logic          a_rvalid;

    exp_t sb[$];
    int   cyc         = 0;
    int   busy_cycles = 0;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   base;

    lzw_dict_ram dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .busy     (busy),
        .a_en     (a_en),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_en     (b_en),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rst && busy) busy_cycles <= busy_cycles + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read results are due on the cycle after issue; any other strobe is spurious.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                check("rvalid", 32'(a_rvalid), 32'd1);
                check("rdata", 32'(a_rdata), 32'(sb[0].data));
                void'(sb.pop_front());
            end else if (a_rvalid) begin
                check("spurious_rvalid", 32'(a_rvalid), 32'd0);
            end
        end
    end

    task automatic drive(input logic ae, input logic awe, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic be, input logic bwe,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(negedge clk);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_wdata = bd;
        flush = 1'b0;
    endtask

    task automatic expect_rd(input logic [DW-1:0] data);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        drive(1'b1, 1'b0, addr, '0, 1'b0, 1'b0, '0, '0);
        expect_rd(data);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_busy_count(input string tag, input int target);
        int n = 0;
        while ((busy_cycles - base) < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy_cycles - base), 32'(target));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rdata", 32'(a_rdata), 32'd0);
        check("rst_rvalid", 32'(a_rvalid), 32'd0);

        // Power-on clear sweep.
        base = busy_cycles;
        rst  = 1'b0;
        wait_idle("por_timeout");
        check("por_busy_len", 32'(busy_cycles - base), 32'(ROWS));
        rd(13'h0000, 13'h0000);
        rd(13'h1FFF, 13'h0000);
        rd(13'h0005, 13'h0000);

        // B write then A read, then hold.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'h0005, 13'h1ABC);
        rd(13'h0005, 13'h1ABC);
        idle();
        repeat (3) @(negedge clk);
        check("hold_rdata", 32'(a_rdata), 32'h1ABC);
        check("hold_rvalid", 32'(a_rvalid), 32'd0);

        // Same-cycle forwarding.
        drive(1'b1, 1'b0, 13'h0010, '0, 1'b1, 1'b1, 13'h0010, 13'h0123);
        expect_rd(13'h0123);

        // Write collision: port B wins.
        drive(1'b1, 1'b1, 13'h0020, 13'h0AAA, 1'b1, 1'b1, 13'h0020, 13'h0555);
        rd(13'h0020, 13'h0555);

        // All four banks, then back-to-back reads.
        drive(1'b1, 1'b1, 13'h0040, 13'd1, 1'b1, 1'b1, 13'h0041, 13'd2);
        drive(1'b1, 1'b1, 13'h0042, 13'd3, 1'b1, 1'b1, 13'h0043, 13'd4);
        drive(1'b1, 1'b1, 13'h0044, 13'h00AB, 1'b1, 1'b1, 13'h0048, 13'h00CD);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 13'h0040, 13'h1FFF);
        rd(13'h0040, 13'd1);
        rd(13'h0041, 13'd2);
        rd(13'h0042, 13'd3);
        rd(13'h0043, 13'd4);
        rd(13'h0044, 13'h00AB);
        rd(13'h0048, 13'h00CD);
        drive(1'b1, 1'b0, 13'h0041, '0, 1'b1, 1'b1, 13'h0045, 13'h0077);
        expect_rd(13'd2);
        rd(13'h0045, 13'h0077);
        idle();

        // Flush with a coincident read (dropped), writes while busy (dropped), re-flush at row 100.
        drive(1'b1, 1'b0, 13'h0040, '0, 1'b0, 1'b0, '0, '0);
        flush = 1'b1;
        base  = busy_cycles;
        drive(1'b1, 1'b1, 13'h0040, 13'h0777, 1'b1, 1'b1, 13'h0041, 13'h0666);
        drive(1'b1, 1'b0, 13'h0042, '0, 1'b0, 1'b0, '0, '0);
        idle();
        wait_busy_count("reach_row99", 99);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle("reflush_timeout");
        check("reflush_busy_len", 32'(busy_cycles - base), 32'(100 + ROWS));
        rd(13'h0040, 13'h0000);
        rd(13'h0041, 13'h0000);
        rd(13'h0042, 13'h0000);
        rd(13'h0043, 13'h0000);
        rd(13'h0005, 13'h0000);

        // Reset in the middle of a sweep restarts it from row 0.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 13'h0040, 13'h0009);
        rd(13'h0040, 13'h0009);
        idle();
        repeat (2) @(negedge clk);
        flush = 1'b1;
        base  = busy_cycles;
        @(negedge clk);
        flush = 1'b0;
        wait_busy_count("reach_row500", 500);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_rdata", 32'(a_rdata), 32'd0);
        check("midrst_rvalid", 32'(a_rvalid), 32'd0);
        base = busy_cycles;
        rst  = 1'b0;
        wait_idle("midrst_timeout");
        check("midrst_busy_len", 32'(busy_cycles - base), 32'(ROWS));
        rd(13'h0040, 13'h0000);
        idle();
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
